// File: rtl/fetch_control_unit.sv
// Purpose: multi-cycle fetch/decode/exec/writeback sequencer; owns the PC and decodes 16-bit instructions.
// Latency: 4 cycles per instruction (FETCH, DECODE, EXEC, WB) plus any FETCH stall cycles.
// Backpressure: run=0 holds the sequencer in FETCH; it is ignored once an instruction has left FETCH.
module fetch_control_unit #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock_reg,
    input  logic              reset,
    input  logic              run,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_data,
    input  logic              zero,
    output logic              reg_we,
    output logic [2:0]        rd_addr,
    output logic [2:0]        rs_addr,
    output logic [2:0]        rt_addr,
    output logic [2:0]        ula_control,
    output logic              src_b_sel,
    output logic [DATA_W-1:0] imm,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_R    = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_BEQ  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t          state_q;
    logic [15:0]     instr_q;
    logic [PC_W-1:0] pc_q;
    logic            branch_q;
    logic            we_q;
    logic            halted_q;

    logic [3:0]      op;
    logic [2:0]      fld_a;
    logic [2:0]      fld_b;
    logic [2:0]      fld_c;
    logic [2:0]      fld_f;
    logic [5:0]      fld_low;
    logic            is_write;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_branch;
    logic [PC_W-1:0] next_pc;

    assign op      = instr_q[15:12];
    assign fld_a   = instr_q[11:9];
    assign fld_b   = instr_q[8:6];
    assign fld_c   = instr_q[5:3];
    assign fld_f   = instr_q[2:0];
    assign fld_low = instr_q[5:0];

    assign is_write = (op == OP_R) || (op == OP_ADDI);

    // Decoded fields come straight from the instruction register, so they hold
    // from EXEC through WB and only change when the next DECODE latches.
    always_comb begin
        rd_addr     = 3'd0;
        rs_addr     = 3'd0;
        rt_addr     = 3'd0;
        ula_control = 3'd0;
        src_b_sel   = 1'b0;
        imm         = '0;
        case (op)
            OP_R: begin
                rd_addr     = fld_a;
                rs_addr     = fld_b;
                rt_addr     = fld_c;
                ula_control = fld_f;
            end
            OP_ADDI: begin
                rd_addr     = fld_a;
                rs_addr     = fld_b;
                imm         = DATA_W'(fld_low);
                ula_control = 3'b010;
                src_b_sel   = 1'b1;
            end
            OP_BEQ: begin
                rs_addr     = fld_a;
                rt_addr     = fld_b;
                ula_control = 3'b110;
            end
            default: ;
        endcase
    end

    // PC arithmetic wraps modulo 2^PC_W; the branch offset is sign-extended.
    assign pc_inc    = pc_q + PC_W'(1);
    assign pc_branch = pc_inc + PC_W'($signed(fld_low));

    // imem_addr is held at pc for the whole instruction, so the ROM word
    // is identical to the latched instruction; the jump target uses the latch.
    always_comb begin
        next_pc = pc_inc;
        case (op)
            OP_BEQ:  next_pc = branch_q ? pc_branch : pc_inc;
            OP_JMP:  next_pc = instr_q[PC_W-1:0];
            OP_HALT: next_pc = pc_q;
            default: next_pc = pc_inc;
        endcase
    end

    always_ff @(posedge clock_reg) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            instr_q  <= '0;
            branch_q <= 1'b0;
            we_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_FETCH: begin
                    if (run) begin
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    instr_q <= imem_data;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    branch_q <= zero;
                    we_q     <= is_write;
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    pc_q <= next_pc;
                    if (op == OP_HALT) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Gate the write pulse so a reset landing in WB never writes the register file.
    assign reg_we    = we_q && !reset;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign state     = state_q;

endmodule
